// File: rtl/aww_types_pkg.sv
// Redirect-unit types: FSM states and flush-vector bit positions.
package aww_types_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HALTED  = 2'd2
  } redirect_state_t;

  // Bit positions inside the [0:1] flushes vector.
  localparam int FLUSH_IFID = 0;
  localparam int FLUSH_IDEX = 1;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/redirect_stats.sv
// Saturating redirect counter; only instantiated when REDIRECT_STATS_EN is defined.
module redirect_stats #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count accepted redirects, sticking at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/redirect_unit.sv
// Redirect unit: merges taken-branch (EX/MEM) and jump (ID/EX) redirects into
// one PC redirect request, holds it while the PC is stalled, and stops on halt.
// Optional redirect counter enabled by defining REDIRECT_STATS_EN.
module redirect_unit
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        exmem_branch,
  input  logic        exmem_taken,
  input  word_t       exmem_target,
  input  logic        idex_jump,
  input  word_t       idex_jtarget,
  input  logic        pc_WEN,
  input  logic        halt,
  output logic        npc_change,
  output word_t       npc,
  output logic [0:1]  flushes,
  output logic        pending,
  output logic [15:0] redirect_cnt
);

  redirect_state_t state, next_state;
  word_t           pend_npc;
  logic            accept;
  logic            taken;

  assign taken = exmem_branch & exmem_taken;

  // State register; reset always returns to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the redirect target whenever the PC cannot take it this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_npc <= '0;
    end else if (accept && !pc_WEN) begin
      pend_npc <= npc;
    end
  end

  // Next-state and redirect outputs; the older branch beats a younger jump,
  // and reset or halt silence every output.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    npc_change = 1'b0;
    npc        = '0;
    flushes    = '0;
    pending    = 1'b0;
    if (!RST) begin
      if (halt) begin
        next_state = HALTED;
      end else begin
        case (state)
          IDLE: begin
            if (taken) begin
              accept                = 1'b1;
              npc                   = exmem_target;
              flushes[FLUSH_IFID]   = 1'b1;
              flushes[FLUSH_IDEX]   = 1'b1;
            end else if (idex_jump) begin
              accept                = 1'b1;
              npc                   = idex_jtarget;
              flushes[FLUSH_IFID]   = 1'b1;
            end
            npc_change = accept;
            if (accept && !pc_WEN) begin
              next_state = PENDING;
            end
          end
          PENDING: begin
            npc_change = 1'b1;
            pending    = 1'b1;
            npc        = pend_npc;
            // A jump here is younger than the held redirect and is dropped.
            if (taken) begin
              accept              = 1'b1;
              npc                 = exmem_target;
              flushes[FLUSH_IFID] = 1'b1;
              flushes[FLUSH_IDEX] = 1'b1;
            end
            if (pc_WEN) begin
              next_state = IDLE;
            end
          end
          HALTED: begin
            next_state = HALTED;
          end
          default: begin
            next_state = IDLE;
          end
        endcase
      end
    end
  end

`ifdef REDIRECT_STATS_EN
  redirect_stats #(.CNT_W(16)) u_stats (
    .CLK (CLK),
    .RST (RST),
    .inc (accept),
    .cnt (redirect_cnt)
  );
`else
  assign redirect_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_redirect_unit.sv
// Directed bench for redirect_unit (counter expectations follow REDIRECT_STATS_EN).
module tb_redirect_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        exmem_branch, exmem_taken, idex_jump, pc_WEN, halt;
  logic [31:0] exmem_target, idex_jtarget;
  logic        npc_change, pending;
  logic [31:0] npc;
  logic [0:1]  flushes;
  logic [15:0] redirect_cnt;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  redirect_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .exmem_branch (exmem_branch),
    .exmem_taken  (exmem_taken),
    .exmem_target (exmem_target),
    .idex_jump    (idex_jump),
    .idex_jtarget (idex_jtarget),
    .pc_WEN       (pc_WEN),
    .halt         (halt),
    .npc_change   (npc_change),
    .npc          (npc),
    .flushes      (flushes),
    .pending      (pending),
    .redirect_cnt (redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample combinational outputs mid-cycle, away from the rising edge.
  task automatic chk_out(input string tag, input logic nc, input logic [31:0] pc,
                         input logic [1:0] fl, input logic pd);
    @(negedge CLK);
    chk({tag, ".npc_change"}, {31'd0, npc_change}, {31'd0, nc});
    chk({tag, ".npc"},        npc, pc);
    chk({tag, ".flushes"},    {30'd0, flushes}, {30'd0, fl});
    chk({tag, ".pending"},    {31'd0, pending}, {31'd0, pd});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic br, input logic tk, input logic [31:0] tgt,
                       input logic jp, input logic [31:0] jt, input logic wen,
                       input logic hl);
    exmem_branch = br; exmem_taken = tk; exmem_target = tgt;
    idex_jump = jp; idex_jtarget = jt; pc_WEN = wen; halt = hl;
  endtask

  task automatic idle_in(input logic wen);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, wen, 1'b0);
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef REDIRECT_STATS_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return 16'h0;
`endif
  endfunction

  initial begin
    // Reset with a taken branch present: outputs must stay quiet.
    RST = 1'b1;
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 1'b0);
    chk_out("rst_hold", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    chk("rst_cnt", {16'd0, redirect_cnt}, 32'h0);
    RST = 1'b0;

    // Taken branch with PC enabled: immediate redirect, then idle.
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_out("br40", 1'b1, 32'h40, 2'b11, 1'b0);
    tick();
    idle_in(1'b1);
    chk_out("br40_after", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();

    // Not-taken branch is no event.
    drive(1'b1, 1'b0, 32'h123, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_out("nt_branch", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();

    // Branch and jump together: branch wins, jump dropped.
    drive(1'b1, 1'b1, 32'h80, 1'b1, 32'h100, 1'b1, 1'b0);
    chk_out("br_vs_jmp", 1'b1, 32'h80, 2'b11, 1'b0);
    tick();
    idle_in(1'b1);
    chk_out("br_vs_jmp_after", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();

    // Lone jump flushes IF/ID only.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h180, 1'b1, 1'b0);
    chk_out("jmp180", 1'b1, 32'h180, 2'b10, 1'b0);
    tick();

    // Jump while PC stalled for three cycles.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0);
    chk_out("jst_c0", 1'b1, 32'h200, 2'b10, 1'b0);
    tick();
    idle_in(1'b0);
    chk_out("jst_c1", 1'b1, 32'h200, 2'b00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h999, 1'b0, 1'b0);
    chk_out("jst_c2_jmp_ignored", 1'b1, 32'h200, 2'b00, 1'b1);
    tick();
    idle_in(1'b1);
    chk_out("jst_c3_release", 1'b1, 32'h200, 2'b00, 1'b1);
    tick();
    idle_in(1'b1);
    chk_out("jst_idle", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();

    // Pending target replaced by a newer taken branch.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0);
    chk_out("rep_c0", 1'b1, 32'h200, 2'b10, 1'b0);
    tick();
    idle_in(1'b0);
    chk_out("rep_c1", 1'b1, 32'h200, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_out("rep_br300", 1'b1, 32'h300, 2'b11, 1'b1);
    tick();
    idle_in(1'b0);
    chk_out("rep_hold300", 1'b1, 32'h300, 2'b00, 1'b1);
    tick();
    idle_in(1'b1);
    chk_out("rep_release", 1'b1, 32'h300, 2'b00, 1'b1);
    tick();
    idle_in(1'b1);
    chk_out("rep_idle", 1'b0, 32'h0, 2'b00, 1'b0);
    // Accepted so far: 0x40, 0x80, 0x180, 0x200, 0x200, 0x300.
    chk("cnt_six", {16'd0, redirect_cnt}, {16'd0, cnt_exp(6)});
    tick();

    // Reset in the middle of PENDING drops the latched target.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b0);
    chk_out("rp_c0", 1'b1, 32'h500, 2'b10, 1'b0);
    tick();
    idle_in(1'b0);
    RST = 1'b1;
    chk_out("rp_in_rst", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    RST = 1'b0;
    idle_in(1'b0);
    chk_out("rp_after", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("rp_cnt", {16'd0, redirect_cnt}, 32'h0);
    tick();

    // Halt overrides a simultaneous taken branch, then sticks.
    drive(1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_out("halt_br", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h640, 1'b1, 32'h680, 1'b1, 1'b0);
    chk_out("halted_1", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 1'b0);
    chk_out("halted_2", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("halt_cnt", {16'd0, redirect_cnt}, 32'h0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h740, 1'b1, 1'b0);
    chk_out("post_halt_rst", 1'b1, 32'h740, 2'b10, 1'b0);
    tick();

    // Halt while PENDING.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 1'b0);
    chk_out("hp_c0", 1'b1, 32'h800, 2'b10, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("hp_halt", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    idle_in(1'b1);
    chk_out("hp_halted", 1'b0, 32'h0, 2'b00, 1'b0);
    tick();

    // Saturation: 65540 accepted redirects from a clean reset.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) begin
      if (i == 3) chk("sat_cnt3", {16'd0, redirect_cnt}, {16'd0, cnt_exp(3)});
      tick();
    end
    idle_in(1'b1);
    chk("sat_cnt", {16'd0, redirect_cnt}, {16'd0, cnt_exp(65540)});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/redirect_unit.md
REDIRECT_UNIT -- requirements
Module: redirect_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; RST  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: exmem_branch  in  1  branch resolved in EX/MEM; exmem_taken  in  1  branch outcome; exmem_target  in  32  branch target.
REQ-003 SHALL have ports: idex_jump  in  1  J/JAL/JR in ID/EX; idex_jtarget  in  32  jump target.
REQ-004 SHALL have ports: pc_WEN  in  1  PC write enable from hazard unit; halt  in  1  halt reached MEM.
REQ-005 SHALL have ports: npc_change  out  1  redirect request to PC and hazard unit; npc  out  32  redirect PC; flushes  out  [0:1]  flush request, bit0=IF/ID, bit1=ID/EX; pending  out  1  redirect waiting on pc_WEN; redirect_cnt  out  16  redirect count.

Function
REQ-006 SHALL implement states IDLE, PENDING, HALTED (redirect_state_t).
REQ-007 SHALL, in IDLE with exmem_branch & exmem_taken, drive same-cycle (combinational) npc_change=1, npc=exmem_target, flushes=2'b11.
REQ-008 SHALL, in IDLE with idex_jump and no taken branch, drive same-cycle npc_change=1, npc=idex_jtarget, flushes=2'b10 (IF/ID only).
REQ-009 SHALL give a taken branch priority over a simultaneous jump (older instruction wins); the jump is discarded, not queued.
REQ-010 SHALL treat a not-taken branch as no event: npc_change=0, flushes=2'b00.
REQ-011 SHALL, when a redirect occurs with pc_WEN=0, latch npc into a pending register and enter PENDING next cycle; flushes SHALL be asserted only in the originating cycle.
REQ-012 SHALL, in PENDING, hold npc_change=1, npc=latched target, pending=1, flushes=2'b00, ignore new jumps, and return to IDLE on the first cycle pc_WEN=1 (inclusive).
REQ-013 SHALL, in PENDING, accept a new taken branch: replace latched target, assert flushes=2'b11 that cycle, remain PENDING if pc_WEN=0.
REQ-014 SHALL, on halt=1 in any state, enter HALTED next cycle; halt SHALL override a same-cycle redirect (npc_change=0, flushes=2'b00).
REQ-015 SHALL, in HALTED, hold all outputs at 0 except redirect_cnt until RST.
REQ-016 SHALL drive npc=32'h0 whenever npc_change=0.

Reset
REQ-017 SHALL, on RST=1 at a CLK edge, enter IDLE, clear pending register to 0, clear redirect_cnt to 0.
REQ-018 SHALL, while RST=1, drive npc_change=0, npc=0, flushes=2'b00, pending=0 regardless of inputs; RST mid-PENDING SHALL drop the latched target.

Configuration
REQ-019 SHALL, with REDIRECT_STATS_EN defined, increment redirect_cnt once per cycle where a new redirect is accepted (REQ-007/008/013), saturating at 16'hFFFF; PENDING hold cycles SHALL NOT count.
REQ-020 SHALL, without REDIRECT_STATS_EN, tie redirect_cnt to 16'h0 and synthesize no counter.

Structure
REQ-021 SHALL place redirect_state_t and constants FLUSH_IFID=0, FLUSH_IDEX=1 in aww_types_pkg; word_t from cpu_types_pkg.
REQ-022 SHALL implement the counter as sub-module redirect_stats (CLK, RST, inc, cnt), instantiated only under REDIRECT_STATS_EN.

Verification
REQ-023 Taken branch, exmem_target=32'h0000_0040, pc_WEN=1 -> same cycle npc_change=1, npc=0x40, flushes=2'b11; next cycle IDLE, outputs 0.
REQ-024 Taken branch 0x80 and jump 0x100 same cycle -> npc=0x80, flushes=2'b11; jump never redirects.
REQ-025 Jump 0x200 with pc_WEN=0 for 3 cycles -> flushes=2'b10 cycle 0 only; npc_change=1, npc=0x200, pending=1 cycles 1-3; IDLE after pc_WEN=1.
REQ-026 PENDING target 0x200, then taken branch 0x300 with pc_WEN=0 -> flushes=2'b11 that cycle, npc=0x300 thereafter until pc_WEN=1.
REQ-027 halt=1 with simultaneous taken branch -> npc_change=0, flushes=0; HALTED until RST; RST asserted mid-PENDING -> all outputs 0 next cycle.
REQ-028 With REDIRECT_STATS_EN, 65540 accepted redirects -> redirect_cnt=16'hFFFF; without macro -> redirect_cnt=0 throughout.
